// File: rtl/sub8_serial.sv
// Bit-serial LSB-first subtractor: out = in0 - in1 mod 2^WIDTH, with unsigned borrow-out.
// One operation at a time under a start/busy/done handshake (IDLE -> RUN -> DONE -> IDLE).
module sub8_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              br_q, br_d;
    logic              borrow_q, borrow_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              diff_bit;
    logic              br_next;
    logic [WIDTH-1:0]  res_shifted;

    // Full-subtractor on the current LSBs of the operand shift registers.
    assign diff_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign res_shifted = {diff_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = in0;
                    b_d     = in1;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shifted;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    out_d    = res_shifted;
                    borrow_d = br_next;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign out    = out_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Self-checking bench for sub8_serial: cycle-level behavioural model checked every cycle,
// plus literal expectations for the directed cases and a randomized adder round-trip.
module tb_sub8_serial;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;

    sub8_serial #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .borrow  (borrow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: m_age counts cycles since acceptance (0 = idle, 1..W = running, W+1 = done cycle).
    int           m_age = 0;
    logic [W-1:0] m_a   = '0;
    logic [W-1:0] m_b   = '0;
    logic [W-1:0] m_out = '0;
    logic         m_bor = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_age <= 0;
            m_out <= '0;
            m_bor <= 1'b0;
        end else if (m_age == 0) begin
            if (start) begin
                m_age <= 1;
                m_a   <= in0;
                m_b   <= in1;
            end
        end else if (m_age == W) begin
            m_age <= W + 1;
            m_out <= W'((int'(m_a) - int'(m_b) + (1 << W)) % (1 << W));
            m_bor <= (int'(m_a) < int'(m_b));
        end else if (m_age == W + 1) begin
            m_age <= 0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_busy", 32'(busy), 32'(m_age >= 1 && m_age <= W));
        check("model_done", 32'(done), 32'(m_age == W + 1));
        check("model_out", 32'(out), 32'(m_out));
        check("model_borrow", 32'(borrow), 32'(m_bor));
    endtask

    task automatic tick();
        @(negedge clock);
        compare_model();
        if (done) done_cnt++;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation; returns edges until done seen and number of busy cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise,
                          output int lat, output int busy_cycles);
        bit seen = 0;
        lat         = 0;
        busy_cycles = 0;
        in0   = x;
        in1   = y;
        start = 1'b1;
        for (int i = 0; i < W + 6; i++) begin
            tick();
            start = 1'b0;
            lat++;
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
            if (noise) begin
                in0   = W'($urandom);
                in1   = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) check("op_timeout", 32'd0, 32'd1);
        if (noise) start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         br;
    } vec_t;

    vec_t t3 [4] = '{
        '{8'h00, 8'h00, 8'h00, 1'b0},
        '{8'hFF, 8'h01, 8'hFE, 1'b0},
        '{8'h00, 8'hFF, 8'h01, 1'b1},
        '{8'h80, 8'h80, 8'h00, 1'b0}
    };

    initial begin
        int lat;
        int bc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] sum;

        reset_n = 1'b1;
        start   = 1'b0;
        in0     = '0;
        in1     = '0;
        #1 reset_n = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        reset_n = 1'b1;
        tick();

        // T1
        run_op(8'h06, 8'h01, 1'b0, lat, bc);
        check("t1_out", 32'(out), 32'h05);
        check("t1_borrow", 32'(borrow), 32'd0);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cycles", 32'(bc), 32'd8);

        // T2
        run_op(8'h01, 8'h06, 1'b0, lat, bc);
        check("t2_out", 32'(out), 32'hFB);
        check("t2_borrow", 32'(borrow), 32'd1);

        // T3
        foreach (t3[i]) begin
            run_op(t3[i].a, t3[i].b, 1'b0, lat, bc);
            check("t3_out", 32'(out), 32'(t3[i].r));
            check("t3_borrow", 32'(borrow), 32'(t3[i].br));
        end

        // T4: start during RUN (cycle 3) and DONE (cycle 9) is ignored
        done_cnt = 0;
        in0   = 8'h10;
        in1   = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        in0   = 8'hAA;
        in1   = 8'h55;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("t4_done_c9", 32'(done), 32'd1);
        check("t4_out", 32'(out), 32'h0D);
        check("t4_borrow", 32'(borrow), 32'd0);
        start = 1'b1;
        tick();
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_one_done", 32'(done_cnt), 32'd1);
        tick();
        start = 1'b0;
        check("t4_reaccept", 32'(busy), 32'd1);
        wait_done();
        check("t4_out2", 32'(out), 32'h55);
        check("t4_borrow2", 32'(borrow), 32'd0);
        tick();

        // T5: asynchronous reset mid-RUN
        in0   = 8'h20;
        in1   = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_out", 32'(out), 32'd0);
        check("t5_borrow", 32'(borrow), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run_op(8'h07, 8'h02, 1'b0, lat, bc);
        check("t5_out_after", 32'(out), 32'h05);

        // T6: round trip through a registered-adder sum
        sum = 8'h06 + 8'h01;
        run_op(sum, 8'h01, 1'b0, lat, bc);
        check("t6_out", 32'(out), 32'h06);
        check("t6_borrow", 32'(borrow), 32'd0);
        for (int i = 0; i < 200; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            sum = ra + rb;
            run_op(sum, rb, 1'b1, lat, bc);
            check("t6_rand_out", 32'(out), 32'(ra));
            check("t6_rand_borrow", 32'(borrow), 32'((int'(ra) + int'(rb)) >= 256));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
